// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment driver: the active-low
// hex glyph table, the all-dark pattern and a width helper.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Segment order {a,b,c,d,e,f,g}; a 0 lights the segment.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble-to-glyph lookup (active-low segments).
module hex_to_seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode seven-segment driver with frame-aligned double
// buffering. Define SEG7_BLINK_EN to add per-digit blinking via blink_mask.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DIV    = 1000,
    parameter int GUARD  = 2
`ifdef SEG7_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     point_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_en,
    input  logic                  en_n,
`ifdef SEG7_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    output logic                  busy,
    output logic                  frame_done,
    output logic [DIGITS-1:0]     an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n
);

    localparam int CNT_W = clog2(DIV);
    localparam int IDX_W = clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic [DIGITS-1:0]   an_n_q, an_n_d;
    logic [6:0]          seg_n_q, seg_n_d;
    logic                dp_n_q, dp_n_d;
    logic [4*DIGITS-1:0] act_data_q, act_data_d;
    logic [DIGITS-1:0]   act_point_q, act_point_d;
    logic [DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
    logic [DIGITS-1:0]   pend_point_q, pend_point_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;

    logic                wrap;
    logic                in_guard;
    logic [3:0]          cur_nib;
    logic [6:0]          hex_seg;
    logic [DIGITS-1:0]   nib_zero;
    logic [DIGITS-1:0]   lz_supp;
    logic                hi_zero;
    logic                blink_dark;
    logic                dark;

    assign wrap    = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    assign cur_nib = act_data_q[4*idx_q +: 4];

    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);
            assign in_guard = (cnt_q < GUARD_C);
        end
    endgenerate

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib_zero
        assign nib_zero[gi] = (act_data_q[4*gi +: 4] == 4'h0);
    end

    // A digit is a leading zero when it and every digit to its left are zero;
    // digit 0 is left out so a value of zero still shows a single "0".
    always_comb begin
        lz_supp = '0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero    = hi_zero & nib_zero[i];
            lz_supp[i] = hi_zero;
        end
    end

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nib),
        .seg_n  (hex_seg)
    );

`ifdef SEG7_BLINK_EN
    localparam int FRM_W = clog2(BLINK_FRAMES);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
    logic             blink_phase_q, blink_phase_d;

    always_comb begin
        frm_cnt_d     = frm_cnt_q;
        blink_phase_d = blink_phase_q;
        if (wrap) begin
            if (frm_cnt_q == FRM_LAST) begin
                frm_cnt_d     = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frm_cnt_d = frm_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_cnt_q     <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            frm_cnt_q     <= frm_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blink_dark = blink_phase_q & blink_mask[idx_q];
`else
    assign blink_dark = 1'b0;
`endif

    assign dark = act_blank_q[idx_q] | en_n | (lz_en & lz_supp[idx_q]) | blink_dark;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Anodes keep scanning while a digit is dark so duty cycle is constant.
        an_n_d       = in_guard ? '1 : ~(DIGITS'(1) << idx_q);
        seg_n_d      = dark ? SEG_OFF : hex_seg;
        dp_n_d       = en_n | ~act_point_q[idx_q];
        frame_done_d = wrap;

        busy_d       = busy_q;
        act_data_d   = act_data_q;
        act_point_d  = act_point_q;
        act_blank_d  = act_blank_q;
        pend_data_d  = pend_data_q;
        pend_point_d = pend_point_q;
        pend_blank_d = pend_blank_q;

        if (load && wrap) begin
            // A load landing on the frame boundary goes straight to the display.
            act_data_d  = data_in;
            act_point_d = point_in;
            act_blank_d = blank_in;
            busy_d      = 1'b0;
        end else begin
            if (wrap && busy_q) begin
                act_data_d  = pend_data_q;
                act_point_d = pend_point_q;
                act_blank_d = pend_blank_q;
                busy_d      = 1'b0;
            end
            if (load) begin
                pend_data_d  = data_in;
                pend_point_d = point_in;
                pend_blank_d = blank_in;
                busy_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            an_n_q       <= '1;
            seg_n_q      <= SEG_OFF;
            dp_n_q       <= 1'b1;
            act_data_q   <= '0;
            act_point_q  <= '0;
            act_blank_q  <= '1;
            pend_data_q  <= '0;
            pend_point_q <= '0;
            pend_blank_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            act_data_q   <= act_data_d;
            act_point_q  <= act_point_d;
            act_blank_q  <= act_blank_d;
            pend_data_q  <= pend_data_d;
            pend_point_q <= pend_point_d;
            pend_blank_q <= pend_blank_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display (4 digits, 4-cycle slots, 1-cycle guard).
module tb_seg7_scan_display;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int GUARD  = 1;
    localparam int FRAME  = DIGITS * DIV;
`ifdef SEG7_BLINK_EN
    localparam int BLINK_FRAMES = 2;
`endif

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  point_in;
    logic [3:0]  blank_in;
    logic        lz_en;
    logic        en_n;
    logic [3:0]  blink_mask;
    logic        busy;
    logic        frame_done;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    always #5 clk = ~clk;

    seg7_scan_display #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .GUARD  (GUARD)
`ifdef SEG7_BLINK_EN
        ,
        .BLINK_FRAMES (BLINK_FRAMES)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .point_in   (point_in),
        .blank_in   (blank_in),
        .lz_en      (lz_en),
        .en_n       (en_n),
`ifdef SEG7_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .busy       (busy),
        .frame_done (frame_done),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n)
    );

    typedef struct packed {
        logic [3:0] an_n;
        logic [6:0] seg_n;
        logic       dp_n;
        logic       busy;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   fd_seen    = 0;

    // Reference model: cycles since reset plus active/pending buffers.
    int          m_cyc = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_point = '0;
    logic [3:0]  m_blank = '1;
    logic [15:0] m_pend_data = '0;
    logic [3:0]  m_pend_point = '0;
    logic [3:0]  m_pend_blank = '0;
    logic        m_busy = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic exp_t predict();
        exp_t       e;
        int         cnt;
        int         idx;
        logic [3:0] nib;
        logic       dark;
        e = '{an_n: 4'hF, seg_n: 7'h7F, dp_n: 1'b1, busy: 1'b0, fd: 1'b0};
        if (!rst) begin
            cnt  = m_cyc % DIV;
            idx  = (m_cyc / DIV) % DIGITS;
            nib  = m_data[4*idx +: 4];
            dark = m_blank[idx] || en_n || (lz_en && idx != 0 && (m_data >> (4*idx)) == 16'h0);
`ifdef SEG7_BLINK_EN
            if (((m_cyc / FRAME) / BLINK_FRAMES) % 2 == 1 && blink_mask[idx]) dark = 1'b1;
`endif
            e.an_n  = (cnt < GUARD) ? 4'hF : ~(4'b0001 << idx);
            e.seg_n = dark ? 7'h7F : SEG_TAB[nib];
            e.dp_n  = en_n || !m_point[idx];
            e.fd    = (m_cyc % FRAME) == FRAME - 1;
        end
        return e;
    endfunction

    task automatic update_model();
        logic wrap;
        if (rst) begin
            m_cyc = 0; m_data = '0; m_point = '0; m_blank = '1;
            m_pend_data = '0; m_pend_point = '0; m_pend_blank = '0; m_busy = 1'b0;
        end else begin
            wrap = (m_cyc % FRAME) == FRAME - 1;
            if (load && wrap) begin
                m_data = data_in; m_point = point_in; m_blank = blank_in; m_busy = 1'b0;
            end else begin
                if (wrap && m_busy) begin
                    m_data = m_pend_data; m_point = m_pend_point; m_blank = m_pend_blank;
                    m_busy = 1'b0;
                end
                if (load) begin
                    m_pend_data = data_in; m_pend_point = point_in; m_pend_blank = blank_in;
                    m_busy = 1'b1;
                end
            end
            m_cyc++;
        end
    endtask

    task automatic step();
        exp_t e;
        e = predict();
        update_model();
        e.busy = m_busy;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("an_n", 16'(an_n), 16'(e.an_n));
        check("seg_n", 16'(seg_n), 16'(e.seg_n));
        check("dp_n", 16'(dp_n), 16'(e.dp_n));
        check("busy", 16'(busy), 16'(e.busy));
        check("frame_done", 16'(frame_done), 16'(e.fd));
        if (frame_done === 1'b1) fd_seen++;
    endtask

    // Scan until the wanted anode is active (bounded), then check its glyph.
    task automatic spot(input string tag, input logic [3:0] an_want,
                        input logic [6:0] seg_want, input logic dp_want);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step();
            if (an_n === an_want) found = 1'b1;
        end
        compared++;
        assert (found) else begin
            mismatched++;
            $error("FAIL %s_scan: observed an_n %b never reached expected %b", tag, an_n, an_want);
        end
        if (found) begin
            check({tag, "_seg"}, 16'(seg_n), 16'(seg_want));
            check({tag, "_dp"}, 16'(dp_n), 16'(dp_want));
        end
        $display("spot %s an_n=%b seg_n=%b dp_n=%b", tag, an_n, seg_n, dp_n);
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        data_in = d; point_in = p; blank_in = b; load = 1'b1;
        step();
        load = 1'b0;
        $display("load data=%h point=%b blank=%b busy=%b", d, p, b, busy);
    endtask

    task automatic to_frame_start();
        for (int i = 0; i < FRAME && (m_cyc % FRAME) != 0; i++) step();
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data_in = '0; point_in = '0; blank_in = '0;
        lz_en = 1'b0; en_n = 1'b0; blink_mask = '0;

        step();
        step();
        check("rst_an_n", 16'(an_n), 16'hF);
        check("rst_seg_n", 16'(seg_n), 16'h7F);
        check("rst_dp_n", 16'(dp_n), 16'h1);
        rst = 1'b0;

        fd_seen = 0;
        repeat (3 * FRAME) step();
        check("fd_count_3_frames", 16'(fd_seen), 16'd3);

        repeat (5) step();
        load_word(16'h1A3F, 4'b0001, 4'b0000);
        check("busy_after_load", 16'(busy), 16'h1);
        to_frame_start();
        check("busy_after_commit", 16'(busy), 16'h0);
        spot("d0_F", 4'b1110, 7'b0111000, 1'b0);
        spot("d1_3", 4'b1101, 7'b0000110, 1'b1);
        spot("d2_A", 4'b1011, 7'b0001000, 1'b1);
        spot("d3_1", 4'b0111, 7'b1001111, 1'b1);

        lz_en = 1'b1;
        load_word(16'h0070, 4'b0000, 4'b0000);
        to_frame_start();
        spot("lz_d0", 4'b1110, 7'b0000001, 1'b1);
        spot("lz_d1", 4'b1101, 7'b0001111, 1'b1);
        spot("lz_d2", 4'b1011, 7'h7F, 1'b1);
        spot("lz_d3", 4'b0111, 7'h7F, 1'b1);
        load_word(16'h0000, 4'b0000, 4'b0000);
        to_frame_start();
        spot("zero_d0", 4'b1110, 7'b0000001, 1'b1);
        spot("zero_d1", 4'b1101, 7'h7F, 1'b1);
        lz_en = 1'b0;

        load_word(16'h1111, 4'b0000, 4'b0000);
        load_word(16'h2222, 4'b0000, 4'b0000);
        to_frame_start();
        spot("last_wins_d0", 4'b1110, 7'b0010010, 1'b1);

        load_word(16'h5555, 4'b0000, 4'b0000);
        for (int i = 0; i < FRAME && (m_cyc % FRAME) != FRAME - 1; i++) step();
        load_word(16'h3333, 4'b1111, 4'b0000);
        check("bypass_busy", 16'(busy), 16'h0);
        spot("bypass_d0", 4'b1110, 7'b0000110, 1'b0);

        repeat (2) step();
        en_n = 1'b1;
        step();
        check("en_n_seg", 16'(seg_n), 16'h7F);
        check("en_n_dp", 16'(dp_n), 16'h1);
        spot("en_n_scan", 4'b1011, 7'h7F, 1'b1);
        en_n = 1'b0;

        load_word(16'h8888, 4'b0000, 4'b0000);
        check("busy_before_rst", 16'(busy), 16'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 16'(busy), 16'h0);
        check("midrst_an_n", 16'(an_n), 16'hF);
        repeat (FRAME + 4) step();
        check("pending_lost_busy", 16'(busy), 16'h0);
        spot("pending_lost_d0", 4'b1110, 7'h7F, 1'b1);

`ifdef SEG7_BLINK_EN
        blink_mask = 4'b0010;
        load_word(16'h8888, 4'b0000, 4'b0000);
        for (int i = 0; i < 8 * FRAME && m_cyc < 2 * FRAME; i++) step();
        spot("blink_dark_d1", 4'b1101, 7'h7F, 1'b1);
        spot("blink_d2_lit", 4'b1011, 7'b0000000, 1'b1);
        for (int i = 0; i < 8 * FRAME && m_cyc < 4 * FRAME; i++) step();
        spot("blink_lit_d1", 4'b1101, 7'b0000000, 1'b1);
        for (int i = 0; i < 8 * FRAME && m_cyc < 8 * FRAME; i++) step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
